// File: rtl/pc_pkg.sv
// Shared op codes for the program-counter / return-address-stack unit.
package pc_pkg;

    localparam int PC_OP_W = 3;

    localparam logic [PC_OP_W-1:0] PC_OP_HOLD   = 3'b000;
    localparam logic [PC_OP_W-1:0] PC_OP_INC    = 3'b001;
    localparam logic [PC_OP_W-1:0] PC_OP_LOAD   = 3'b010;
    localparam logic [PC_OP_W-1:0] PC_OP_BRANCH = 3'b011;
    localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'b100;
    localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'b101;

endpackage

// File: rtl/pc_stack_unit_ras_lifo.sv
// Return-address LIFO: un-reset storage array plus a reset SP counter.
// top_data always shows the newest entry (mem[sp-1]); it is meaningless while empty.
module ras_lifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    output logic [DATA_W-1:0]          top_data,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_m1;

    assign sp_m1    = sp_q - SP_W'(1);
    assign sp       = sp_q;
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign top_data = mem[sp_m1[IDX_W-1:0]];

    // Overflowing pushes and underflowing pops are dropped here as a second guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (clr) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && push && !full) begin
            mem[sp_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative branch, call/return through a RAS,
// and a sticky stack-fault flag.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pc_clr,
    input  logic                         pc_en,
    input  logic [PC_OP_W-1:0]           pc_op,
    input  logic [PC_W-1:0]              pc_target,
    input  logic [PC_W-1:0]              pc_offset,
    output logic [PC_W-1:0]              pc,
    output logic [$clog2(RAS_DEPTH):0]   sp,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         stk_err
);

    // pc_en qualifies pc_op like a valid: the op executes on the edge where
    // pc_en=1; the unit is always ready, there is no back-pressure.

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] ras_top;
    logic            push;
    logic            pop;
    logic            fault;
    logic            err_q;

    assign pc       = pc_q;
    assign stk_err  = err_q;
    assign pc_plus1 = pc_q + PC_W'(1);

    ras_lifo #(
        .DATA_W (PC_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pc_clr),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (ras_top),
        .sp        (sp),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_next = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        fault   = 1'b0;
        if (pc_en && !pc_clr) begin
            case (pc_op)
                PC_OP_INC:    pc_next = pc_plus1;
                PC_OP_LOAD:   pc_next = pc_target;
                PC_OP_BRANCH: pc_next = pc_q + pc_offset;
                PC_OP_CALL: begin
                    if (stk_full) begin
                        fault = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = pc_target;
                    end
                end
                PC_OP_RET: begin
                    if (stk_empty) begin
                        fault = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = ras_top;
                    end
                end
                default: pc_next = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else if (pc_clr) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (fault) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit at PC_W=8 and PC_W=12 (RAS_DEPTH=4): directed ops,
// expected state queued at issue time and compared by per-instance monitors.
module tb_pc_stack_unit;
    import pc_pkg::*;

    localparam int SP_W = 3;
    localparam int W8   = 8 + SP_W + 3;
    localparam int W12  = 12 + SP_W + 3;

    logic clk;
    logic rst_n;

    logic            clr8, en8;
    logic [2:0]      op8;
    logic [7:0]      tgt8, off8, pc8;
    logic [SP_W-1:0] sp8;
    logic            full8, empty8, err8;

    logic            clr12, en12;
    logic [2:0]      op12;
    logic [11:0]     tgt12, off12, pc12;
    logic [SP_W-1:0] sp12;
    logic            full12, empty12, err12;

    logic [W8-1:0]  exp_q[$];
    logic [W12-1:0] exp12_q[$];
    string          name_q[$];
    string          name12_q[$];
    logic           issue8, issue12;

    int checks;
    int failures;

    pc_stack_unit #(.PC_W(8), .RAS_DEPTH(4), .RESET_VEC(8'h00)) dut8 (
        .clk(clk), .rst_n(rst_n), .pc_clr(clr8), .pc_en(en8), .pc_op(op8),
        .pc_target(tgt8), .pc_offset(off8), .pc(pc8), .sp(sp8),
        .stk_full(full8), .stk_empty(empty8), .stk_err(err8)
    );

    pc_stack_unit #(.PC_W(12), .RAS_DEPTH(4), .RESET_VEC(12'h000)) dut12 (
        .clk(clk), .rst_n(rst_n), .pc_clr(clr12), .pc_en(en12), .pc_op(op12),
        .pc_target(tgt12), .pc_offset(off12), .pc(pc12), .sp(sp12),
        .stk_full(full12), .stk_empty(empty12), .stk_err(err12)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h ({pc,sp,full,empty,err})", nm, act, exp);
        end
    endtask

    // driver tasks
    task automatic step8(input string nm, input logic clr, input logic en, input logic [2:0] op,
                         input logic [7:0] tgt, input logic [7:0] off,
                         input logic [7:0] e_pc, input logic [SP_W-1:0] e_sp, input logic e_err);
        @(negedge clk);
        clr8 = clr; en8 = en; op8 = op; tgt8 = tgt; off8 = off;
        exp_q.push_back({e_pc, e_sp, (e_sp == 3'd4), (e_sp == 3'd0), e_err});
        name_q.push_back(nm);
        issue8 = 1'b1;
    endtask

    task automatic step12(input string nm, input logic [2:0] op,
                          input logic [11:0] tgt, input logic [11:0] off,
                          input logic [11:0] e_pc, input logic [SP_W-1:0] e_sp, input logic e_err);
        @(negedge clk);
        clr12 = 1'b0; en12 = 1'b1; op12 = op; tgt12 = tgt; off12 = off;
        exp12_q.push_back({e_pc, e_sp, (e_sp == 3'd4), (e_sp == 3'd0), e_err});
        name12_q.push_back(nm);
        issue12 = 1'b1;
    endtask

    // scoreboard monitors: one queued expectation per issued op, checked after its edge
    always @(posedge clk) begin
        if (issue8) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb8_underflow: got output with no expectation queued");
            end else begin
                check(name_q.pop_front(), 32'({pc8, sp8, full8, empty8, err8}), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        if (issue12) begin
            #1;
            if (exp12_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb12_underflow: got output with no expectation queued");
            end else begin
                check(name12_q.pop_front(), 32'({pc12, sp12, full12, empty12, err12}), 32'(exp12_q.pop_front()));
            end
        end
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; issue8 = 1'b0; issue12 = 1'b0;
        clr8 = 0; en8 = 0; op8 = PC_OP_HOLD; tgt8 = '0; off8 = '0;
        clr12 = 0; en12 = 0; op12 = PC_OP_HOLD; tgt12 = '0; off12 = '0;

        #12;
        check("reset_state8", 32'({pc8, sp8, full8, empty8, err8}), 32'({8'h00, 3'd0, 1'b0, 1'b1, 1'b0}));
        check("reset_state12", 32'({pc12, sp12, full12, empty12, err12}), 32'({12'h000, 3'd0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk) rst_n = 1'b1;

        // INC stream, then async reset between edges while INC is still applied
        step8("inc_a", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'h01, 3'd0, 0);
        step8("inc_b", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'h02, 3'd0, 0);
        step8("call_pre_rst", 0, 1, PC_OP_CALL, 8'h90, 8'h00, 8'h90, 3'd1, 0);
        step8("inc_c", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'h91, 3'd1, 0);
        @(negedge clk) issue8 = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_mid_inc", 32'({pc8, sp8, full8, empty8, err8}), 32'({8'h00, 3'd0, 1'b0, 1'b1, 1'b0}));
        en8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // increment wrap, hold, disabled
        step8("load_fe", 0, 1, PC_OP_LOAD, 8'hFE, 8'h00, 8'hFE, 3'd0, 0);
        step8("inc_ff", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'hFF, 3'd0, 0);
        step8("inc_wrap_00", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'h00, 3'd0, 0);
        step8("inc_01", 0, 1, PC_OP_INC, 8'h00, 8'h00, 8'h01, 3'd0, 0);
        step8("hold", 0, 1, PC_OP_HOLD, 8'hAA, 8'h55, 8'h01, 3'd0, 0);
        step8("en0_inc", 0, 0, PC_OP_INC, 8'h00, 8'h00, 8'h01, 3'd0, 0);
        step8("en0_call", 0, 0, PC_OP_CALL, 8'h44, 8'h00, 8'h01, 3'd0, 0);

        // load / branch
        step8("load_cb", 0, 1, PC_OP_LOAD, 8'hCB, 8'h77, 8'hCB, 3'd0, 0);
        step8("branch_m5", 0, 1, PC_OP_BRANCH, 8'h12, 8'hFB, 8'hC6, 3'd0, 0);
        step8("branch_p16", 0, 1, PC_OP_BRANCH, 8'h00, 8'h10, 8'hD6, 3'd0, 0);
        step8("load_02", 0, 1, PC_OP_LOAD, 8'h02, 8'h00, 8'h02, 3'd0, 0);
        step8("branch_wrap", 0, 1, PC_OP_BRANCH, 8'h00, 8'hFE, 8'h00, 3'd0, 0);

        // nested call / return
        step8("load_10", 0, 1, PC_OP_LOAD, 8'h10, 8'h00, 8'h10, 3'd0, 0);
        step8("call_40", 0, 1, PC_OP_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 0);
        step8("call_80", 0, 1, PC_OP_CALL, 8'h80, 8'h00, 8'h80, 3'd2, 0);
        step8("ret_41", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h41, 3'd1, 0);
        step8("ret_11", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h11, 3'd0, 0);

        // overflow / underflow
        step8("call_20", 0, 1, PC_OP_CALL, 8'h20, 8'h00, 8'h20, 3'd1, 0);
        step8("call_30", 0, 1, PC_OP_CALL, 8'h30, 8'h00, 8'h30, 3'd2, 0);
        step8("call_40b", 0, 1, PC_OP_CALL, 8'h40, 8'h00, 8'h40, 3'd3, 0);
        step8("call_50_full", 0, 1, PC_OP_CALL, 8'h50, 8'h00, 8'h50, 3'd4, 0);
        step8("call_99_ovf", 0, 1, PC_OP_CALL, 8'h99, 8'h00, 8'h50, 3'd4, 1);
        step8("ret_41b", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h41, 3'd3, 1);
        step8("ret_31", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h31, 3'd2, 1);
        step8("ret_21", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h21, 3'd1, 1);
        step8("ret_12", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h12, 3'd0, 1);
        step8("ret_udf", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h12, 3'd0, 1);
        step8("clr", 1, 1, PC_OP_INC, 8'h00, 8'h00, 8'h00, 3'd0, 0);
        step8("ret_after_clr", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h00, 3'd0, 1);
        step8("clr_with_fault", 1, 1, PC_OP_RET, 8'h00, 8'h00, 8'h00, 3'd0, 0);
        step8("load_77", 0, 1, PC_OP_LOAD, 8'h77, 8'h00, 8'h77, 3'd0, 0);
        step8("clr_en0", 1, 0, PC_OP_INC, 8'h00, 8'h00, 8'h00, 3'd0, 0);

        // pushed return address wraps
        step8("load_ff", 0, 1, PC_OP_LOAD, 8'hFF, 8'h00, 8'hFF, 3'd0, 0);
        step8("call_at_ff", 0, 1, PC_OP_CALL, 8'h60, 8'h00, 8'h60, 3'd1, 0);
        step8("ret_wrap_00", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h00, 3'd0, 0);

        // reserved ops
        step8("load_33", 0, 1, PC_OP_LOAD, 8'h33, 8'h00, 8'h33, 3'd0, 0);
        step8("rsv7", 0, 1, 3'b111, 8'h55, 8'h00, 8'h33, 3'd0, 0);
        step8("call_70", 0, 1, PC_OP_CALL, 8'h70, 8'h00, 8'h70, 3'd1, 0);
        step8("rsv6", 0, 1, 3'b110, 8'h55, 8'h12, 8'h70, 3'd1, 0);
        step8("ret_34", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h34, 3'd0, 0);
        step8("ret_udf2", 0, 1, PC_OP_RET, 8'h00, 8'h00, 8'h34, 3'd0, 1);
        step8("rsv7_err", 0, 1, 3'b111, 8'h55, 8'h00, 8'h34, 3'd0, 1);
        @(negedge clk) begin issue8 = 1'b0; en8 = 1'b0; end

        // 12-bit instance
        step12("w12_load_ffe", PC_OP_LOAD, 12'hFFE, 12'h000, 12'hFFE, 3'd0, 0);
        step12("w12_inc_fff", PC_OP_INC, 12'h000, 12'h000, 12'hFFF, 3'd0, 0);
        step12("w12_inc_wrap", PC_OP_INC, 12'h000, 12'h000, 12'h000, 3'd0, 0);
        step12("w12_rsv7", 3'b111, 12'h555, 12'h000, 12'h000, 3'd0, 0);
        step12("w12_branch_m1", PC_OP_BRANCH, 12'h000, 12'hFFF, 12'hFFF, 3'd0, 0);
        step12("w12_call", PC_OP_CALL, 12'h123, 12'h000, 12'h123, 3'd1, 0);
        step12("w12_ret_wrap", PC_OP_RET, 12'h000, 12'h000, 12'h000, 3'd0, 0);
        @(negedge clk) begin issue12 = 1'b0; en12 = 1'b0; end

        // bounded drain of any outstanding expectations
        for (int i = 0; i < 10 && (exp_q.size() != 0 || exp12_q.size() != 0); i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || exp12_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0", exp_q.size(), exp12_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
